// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, IF/EX pipeline register, EPC/EXL tracking.
// Build option: define BRANCH_DELAY_SLOT_EN to keep the slot after a jump/branch.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0180,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_branch,
  input  logic        ex_zero,
  input  logic [31:0] ex_branch_target,
  input  logic        ex_jump,
  input  logic [31:0] ex_jump_target,
  input  logic        ex_overflow,
  input  logic        ex_eret,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        if_valid,
  output logic [31:0] epc,
  output logic        exl,
  output logic        redirect
);

  typedef enum logic {ST_NORMAL = 1'b0, ST_EXL = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] epc_q, epc_d;

  logic tb_ev, jp_ev, ex_ev, er_ev;

  assign tb_ev = ex_valid & ex_branch & ex_zero;
  assign jp_ev = ex_valid & ex_jump;
  assign ex_ev = ex_valid & ex_overflow;
  assign er_ev = ex_valid & ex_eret;

  // Stall freezes the whole stage; EX re-presents its event next cycle.
  assign redirect = (ex_ev | er_ev | jp_ev | tb_ev) & ~stall & ~reset;

  always_comb begin
    pc_d       = pc_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    if_valid_d = if_valid_q;
    epc_d      = epc_q;
    state_d    = state_q;
    if (!stall) begin
      if (ex_ev) begin
        pc_d       = EXC_VECTOR;
        if_instr_d = NOP_INSTR;
        if_valid_d = 1'b0;
        // A nested overflow keeps the EPC of the original fault.
        if (state_q == ST_NORMAL) begin
          epc_d   = ex_pc;
          state_d = ST_EXL;
        end
      end else if (er_ev) begin
        pc_d       = epc_q;
        if_instr_d = NOP_INSTR;
        if_valid_d = 1'b0;
        state_d    = ST_NORMAL;
      end else if (jp_ev || tb_ev) begin
        pc_d = jp_ev ? ex_jump_target : ex_branch_target;
`ifdef BRANCH_DELAY_SLOT_EN
        if_instr_d = imem_rdata;
        if_pc_d    = pc_q;
        if_valid_d = 1'b1;
`else
        if_instr_d = NOP_INSTR;
        if_valid_d = 1'b0;
`endif
      end else begin
        pc_d       = pc_q + 32'd4;
        if_instr_d = imem_rdata;
        if_pc_d    = pc_q;
        if_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      if_instr_q <= NOP_INSTR;
      if_pc_q    <= RESET_PC;
      if_valid_q <= 1'b0;
      epc_q      <= 32'h0000_0000;
      state_q    <= ST_NORMAL;
    end else begin
      pc_q       <= pc_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      if_valid_q <= if_valid_d;
      epc_q      <= epc_d;
      state_q    <= state_d;
    end
  end

  // EXL is the FSM state itself, so it doubles as the state debug view.
  assign exl         = (state_q == ST_EXL);
  assign imem_addr   = pc_q;
  assign if_instr    = if_instr_q;
  assign if_pc       = if_pc_q;
  assign if_pc_plus4 = if_pc_q + 32'd4;
  assign if_valid    = if_valid_q;
  assign epc         = epc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle expected outputs go into a queue,
// a negedge monitor pops and compares them against the DUT.
module tb_fetch_unit;

`ifdef BRANCH_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  localparam logic [3:0] NONE = 4'b0000;
  localparam logic [3:0] BR   = 4'b0001;
  localparam logic [3:0] JMP  = 4'b0010;
  localparam logic [3:0] ERET = 4'b0100;
  localparam logic [3:0] OVF  = 4'b1000;
  localparam logic [31:0] PAT = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic [31:0] imem_addr, imem_rdata;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_pc = '0;
  logic        ex_branch = 1'b0;
  logic        ex_zero = 1'b0;
  logic [31:0] ex_branch_target = '0;
  logic        ex_jump = 1'b0;
  logic [31:0] ex_jump_target = '0;
  logic        ex_overflow = 1'b0;
  logic        ex_eret = 1'b0;
  logic [31:0] if_instr, if_pc, if_pc_plus4, epc;
  logic        if_valid, exl, redirect;

  // record: {chk[1:0], pc, if_pc, epc, if_valid, exl, redirect}
  logic [100:0] exp_q[$];
  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr ^ PAT;

  fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_branch(ex_branch), .ex_zero(ex_zero), .ex_branch_target(ex_branch_target),
    .ex_jump(ex_jump), .ex_jump_target(ex_jump_target),
    .ex_overflow(ex_overflow), .ex_eret(ex_eret),
    .if_instr(if_instr), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4),
    .if_valid(if_valid), .epc(epc), .exl(exl), .redirect(redirect)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  // Driver: one call per cycle; expectations describe the outputs seen during that cycle.
  task automatic cyc(input logic rst, input logic stl, input logic ev, input logic [3:0] evm,
                     input logic zr, input logic [31:0] xpc, input logic [31:0] tgt,
                     input logic [1:0] ck, input logic [31:0] e_pc, input logic [31:0] e_ifpc,
                     input logic [31:0] e_epc, input logic e_ifv, input logic e_exl,
                     input logic e_red);
    @(posedge clk);
    #1;
    reset            = rst;
    stall            = stl;
    ex_valid         = ev;
    ex_pc            = xpc;
    ex_branch        = evm[0];
    ex_zero          = zr;
    ex_branch_target = tgt;
    ex_jump          = evm[1];
    ex_jump_target   = tgt;
    ex_eret          = evm[2];
    ex_overflow      = evm[3];
    exp_q.push_back({ck, e_pc, e_ifpc, e_epc, e_ifv, e_exl, e_red});
  endtask

  // Monitor
  always @(negedge clk) begin
    logic [100:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e[99]) begin
        check("imem_addr", imem_addr, e[98:67]);
        check("epc", epc, e[34:3]);
        check("if_valid", {31'd0, if_valid}, {31'd0, e[2]});
        check("exl", {31'd0, exl}, {31'd0, e[1]});
        check("redirect", {31'd0, redirect}, {31'd0, e[0]});
        check("if_instr", if_instr, e[2] ? (e[66:35] ^ PAT) : 32'h0000_0000);
      end
      if (e[100]) begin
        check("if_pc", if_pc, e[66:35]);
        check("if_pc_plus4", if_pc_plus4, e[66:35] + 32'd4);
      end
    end
  end

  initial begin
    // reset, with a jump presented during reset: redirect must stay low
    cyc(1,0,0,NONE,0,0,0,             2'b00, 32'h0,0,0,0,0,0);
    cyc(1,0,1,JMP,0,0,32'h300,        2'b11, 32'h0,0,0,0,0,0);
    // sequential fetch
    cyc(0,0,0,NONE,0,0,0,             2'b11, 32'h0,32'h0,0,0,0,0);
    cyc(0,0,0,NONE,0,0,0,             2'b11, 32'h4,32'h0,0,1,0,0);
    cyc(0,0,0,NONE,0,0,0,             2'b11, 32'h8,32'h4,0,1,0,0);
    cyc(0,0,0,NONE,0,0,0,             2'b11, 32'hC,32'h8,0,1,0,0);
    // taken branch at PC=0x10 to 0x40
    cyc(0,0,1,BR,1,32'h8,32'h40,      2'b11, 32'h10,32'hC,0,1,0,1);
    cyc(0,0,0,NONE,0,0,0,             {DS,1'b1}, 32'h40,32'h10,0,DS,0,0);
    // untaken branch
    cyc(0,0,1,BR,0,32'h40,32'h80,     2'b11, 32'h44,32'h40,0,1,0,0);
    // stall three cycles with a pending taken branch, then take it
    cyc(0,1,1,BR,1,32'h44,32'h100,    2'b11, 32'h48,32'h44,0,1,0,0);
    cyc(0,1,1,BR,1,32'h44,32'h100,    2'b11, 32'h48,32'h44,0,1,0,0);
    cyc(0,1,1,BR,1,32'h44,32'h100,    2'b11, 32'h48,32'h44,0,1,0,0);
    cyc(0,0,1,BR,1,32'h44,32'h100,    2'b11, 32'h48,32'h44,0,1,0,1);
    // jump without ex_valid is ignored
    cyc(0,0,0,JMP,0,0,32'h1C,         {DS,1'b1}, 32'h100,32'h48,0,DS,0,0);
    // overflow, then nested overflow, then eret
    cyc(0,0,1,OVF,0,32'h20,0,         2'b11, 32'h104,32'h100,0,1,0,1);
    cyc(0,0,0,NONE,0,0,0,             2'b01, 32'h180,0,32'h20,0,1,0);
    cyc(0,0,1,OVF,0,32'h184,0,        2'b11, 32'h184,32'h180,32'h20,1,1,1);
    cyc(0,0,1,ERET,0,0,0,             2'b01, 32'h180,0,32'h20,0,1,1);
    // simultaneous events: exception wins; eret beats jump; eret in NORMAL
    cyc(0,0,1,OVF|JMP|BR,1,32'h50,32'h300, 2'b01, 32'h20,0,32'h20,0,0,1);
    cyc(0,0,1,ERET|JMP,0,0,32'h300,   2'b01, 32'h180,0,32'h50,0,1,1);
    cyc(0,0,1,ERET,0,0,0,             2'b01, 32'h50,0,32'h50,0,0,1);
    // jump near the top of memory, then wrap
    cyc(0,0,1,JMP,0,0,32'hFFFF_FFF8,  2'b01, 32'h50,0,32'h50,0,0,1);
    cyc(0,0,0,NONE,0,0,0,             {DS,1'b1}, 32'hFFFF_FFF8,32'h50,32'h50,DS,0,0);
    cyc(0,0,0,NONE,0,0,0,             2'b11, 32'hFFFF_FFFC,32'hFFFF_FFF8,32'h50,1,0,0);
    // stall, then reset asserted mid-stall
    cyc(0,1,0,NONE,0,0,0,             2'b11, 32'h0,32'hFFFF_FFFC,32'h50,1,0,0);
    cyc(1,1,1,JMP,0,0,32'h300,        2'b11, 32'h0,32'hFFFF_FFFC,32'h50,1,0,0);
    cyc(0,0,0,NONE,0,0,0,             2'b11, 32'h0,32'h0,0,0,0,0);
    cyc(0,0,0,NONE,0,0,0,             2'b11, 32'h4,32'h0,0,1,0,0);
    repeat (2) @(posedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the 2-stage pipeline; sits directly upstream of the execute stage and consumes the ALU's `zero` (branch-taken) and overflow `flag` outputs.
- Holds the PC and drives the instruction-memory address.
- Registers the fetched instruction into the IF/EX pipeline register.
- Redirects on taken branches, jumps, overflow exceptions and exception return, and tracks EPC and the exception level (EXL).

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded by reset.
- EXC_VECTOR, 32'h0000_0180, PC loaded on overflow exception.
- NOP_INSTR, 32'h0000_0000, word inserted into IF/EX on flush.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  freeze PC, IF/EX, EPC and state this cycle
- imem_addr  out  32  = PC, combinational from the PC register
- imem_rdata  in  32  instruction at imem_addr, asynchronous read, valid same cycle
- ex_valid  in  1  EX stage holds a real instruction
- ex_pc  in  32  PC of the EX-stage instruction
- ex_branch  in  1  EX instruction is a conditional branch
- ex_zero  in  1  ALU zero output (1 = branch condition met)
- ex_branch_target  in  32  branch target computed by the decoder
- ex_jump  in  1  EX instruction is j/jal/jr
- ex_jump_target  in  32  jump target
- ex_overflow  in  1  ALU overflow flag, qualified by the decoder for add/addi
- ex_eret  in  1  EX instruction is eret
- if_instr  out  32  registered instruction to EX
- if_pc  out  32  registered PC of if_instr
- if_pc_plus4  out  32  if_pc + 4
- if_valid  out  1  if_instr is a real instruction (0 = bubble)
- epc  out  32  exception PC
- exl  out  1  exception level, 1 while in handler
- redirect  out  1  combinational: a PC redirect is being taken this cycle

Behaviour:
- **Reset values:** PC=RESET_PC, if_instr=NOP_INSTR, if_pc=RESET_PC, if_valid=0, epc=0, exl=0, state=NORMAL. Reset overrides stall.
- **Event qualification:**
  - Taken branch: tb = ex_valid & ex_branch & ex_zero.
  - Jump: jp = ex_valid & ex_jump.
  - Exception: ex = ex_valid & ex_overflow.
  - Return: er = ex_valid & ex_eret.
- **Priority, highest first:** reset > stall > ex > er > jp > tb > sequential.
- **Stall:** all registers hold. EX inputs are ignored, because EX is frozen too and re-presents them next cycle. redirect=0.
- **Sequential step:** if_instr<=imem_rdata, if_pc<=PC, if_valid<=1, PC<=PC+4.
- **Exception (ex):**
  - PC<=EXC_VECTOR; IF/EX flushed (NOP_INSTR, if_valid=0).
  - In NORMAL: epc<=ex_pc, exl<=1, state->EXL.
  - In EXL (nested): epc unchanged, state stays EXL, redirect still taken.
- **Return (er):**
  - PC<=epc; IF/EX flushed; exl<=0; state->NORMAL.
  - er in NORMAL: still redirects to epc and leaves exl=0.
- **Jump / taken branch:** PC<=target. IF/EX handling is per the Optional Feature. exl and epc unchanged.
- **Untaken branch** (ex_branch=1, ex_zero=0): sequential step.
- **Redirect output:** redirect=(ex|er|jp|tb)&~stall&~reset.
- **Arithmetic:** all PC arithmetic is modulo 2^32. PC 32'hFFFF_FFFC wraps to 0. Targets are used unmodified, with no alignment check.
- **Pipeline shape:** FSM has two states, NORMAL and EXL. Latency is 1 cycle from PC to if_instr. Redirect penalty is 1 bubble (flush), or 0 with delay slot.

Optional Feature:
- Macro: BRANCH_DELAY_SLOT_EN.
- **Defined:** on jp or tb, IF/EX performs the sequential capture (if_instr<=imem_rdata, if_pc<=PC, if_valid<=1). The instruction after the branch executes.
- **Undefined:** on jp or tb, IF/EX is flushed (NOP_INSTR, if_valid=0).
- ex and er always flush, in both builds.

Test Plan:
- **Reset and fetch:** reset high 2 cycles, then low; imem_rdata=addr-dependent pattern → if_valid=0 first cycle, then if_pc=0,4,8 in order, if_pc_plus4=if_pc+4.
- **Taken branch:** ex_branch=1, ex_zero=1, target=0x40 at PC=0x10 → next PC=0x40.
  - Macro off: one bubble (if_valid=0).
  - Macro on: if_pc=0x10 valid, then 0x40.
  - Same with ex_zero=0 → sequential 0x14.
- **Stall:** stall=1 for 3 cycles during a pending taken branch → PC, if_* and epc frozen, redirect=0; branch taken on the first unstalled cycle.
- **Overflow:** ex_overflow=1, ex_pc=0x20 → PC=0x180, epc=0x20, exl=1, if_valid=0. Second overflow in handler with ex_pc=0x184 → PC=0x180, epc still 0x20.
- **eret:** ex_eret in EXL → PC=epc=0x20, exl=0.
- **Simultaneous events and wrap:**
  - ex_overflow+ex_jump+tb same cycle → exception wins (PC=0x180).
  - PC=0xFFFF_FFFC sequential step → PC=0.
  - Reset asserted mid-stall → all outputs return to reset values next cycle.
